// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding mux selects and the
// per-stage stall/flush bundle driven into the five-stage pipeline.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,  // operand comes from the register file read in D
      FWD_W  = 2'b01,  // operand bypassed from the W-stage result
      FWD_M  = 2'b10   // operand bypassed from the M-stage result
   } fwd_sel_t;

   typedef struct packed {
      logic stallF;
      logic stallD;
      logic stallE;
      logic stallM;
      logic flushD;
      logic flushE;
      logic flushW;
   } pipeCtrl_t;

endpackage

// File: rtl/md_scoreboard.sv
// Register scoreboard for the variable-latency mul/div unit. Tracks which
// architectural registers await a mul/div result and how many ops are in
// flight, so D can stall on a pending source and E can stall when full.
module md_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int NUM_REGS = 32,
   parameter int MD_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  logic [REG_AW-1:0] rd,
   input  logic              done,
   input  logic [REG_AW-1:0] done_rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   output logic              hit,
   output logic              full
);

   localparam int              CNT_W   = $clog2(MD_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_DEPTH);

   logic [NUM_REGS-1:0] pending;
   logic [CNT_W-1:0]    count;
   logic                doneOk;

   // A completion with nothing outstanding is a protocol error; it must not
   // clear a bit or underflow the counter (e.g. late pulses after a reset).
   assign doneOk = done && (count != '0);

   // Pending bits and in-flight count; x0 is never marked so it never hazards.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         count   <= '0;
      end else begin
         if (doneOk) pending[done_rd] <= 1'b0;
         // NOTE: the later non-blocking assignment to the same bit wins, so a
         // same-cycle issue and completion on one register leaves it pending.
         if (issue && (rd != '0)) pending[rd] <= 1'b1;
         if (issue && !doneOk && (count != CNT_MAX)) count <= count + 1'b1;
         else if (!issue && doneOk)                  count <= count - 1'b1;
      end
   end

   assign hit  = pending[rs1] | pending[rs2];
   assign full = (count == CNT_MAX);

   mdDoneLegal: assert property (@(posedge clk) disable iff (rst) !(done && (count == '0)));

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: E-stage forwarding, load-use / no-forwarding RAW
// stalls, mul/div scoreboard stalls, memory wait, branch flush and a
// stall-cycle performance counter.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int NUM_REGS = 32,
   parameter int FWD_EN   = 1,
   parameter int MD_DEPTH = 2,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              LoadE,
   input  logic              PCSrc,
   input  logic              MdStartE,
   input  logic              MdDone,
   input  logic [REG_AW-1:0] MdDoneRd,
   input  logic              MemReqM,
   input  logic              MemReadyM,
   output logic [1:0]        ForwardA,
   output logic [1:0]        ForwardB,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushW,
   output logic [PERF_W-1:0] StallCount
);

   fwd_sel_t  fwdA, fwdB;
   pipeCtrl_t ctrl;
   logic      memWait, rawE, rawM, rawW, ldUse, noFwd, sbHit, sbFull, mdFull, mdIssue;

   // A producer matches a consumer source unless that source is x0.
   function automatic logic srcHit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] src);
      return (src != '0) && (rd == src);
   endfunction

   // E-operand bypass select; the younger M result shadows W.
   always_comb begin
      fwdA = FWD_RF;
      fwdB = FWD_RF;
      if ((FWD_EN != 0) && !rst) begin
         if (RegWriteM && srcHit(RdM, Rs1E))      fwdA = FWD_M;
         else if (RegWriteW && srcHit(RdW, Rs1E)) fwdA = FWD_W;
         if (RegWriteM && srcHit(RdM, Rs2E))      fwdB = FWD_M;
         else if (RegWriteW && srcHit(RdW, Rs2E)) fwdB = FWD_W;
      end
   end

   assign ForwardA = fwdA;
   assign ForwardB = fwdB;

   assign rawE    = RegWriteE && (srcHit(RdE, Rs1D) || srcHit(RdE, Rs2D));
   assign rawM    = RegWriteM && (srcHit(RdM, Rs1D) || srcHit(RdM, Rs2D));
   assign rawW    = RegWriteW && (srcHit(RdW, Rs1D) || srcHit(RdW, Rs2D));
   assign ldUse   = (FWD_EN != 0) && LoadE && rawE;
   assign noFwd   = (FWD_EN == 0) && (rawE || rawM || rawW);
   assign memWait = MemReqM && !MemReadyM;
   assign mdFull  = MdStartE && sbFull;

   // Prioritised stall/flush decision; memory wait freezes everything.
   always_comb begin
      // NOTE: assign the whole bundle a default first so every path drives it
      // and no latch is inferred.
      ctrl = '0;
      if (rst) begin
         ctrl.flushD = 1'b1;
         ctrl.flushE = 1'b1;
         ctrl.flushW = 1'b1;
      end else if (memWait) begin
         ctrl.stallF = 1'b1;
         ctrl.stallD = 1'b1;
         ctrl.stallE = 1'b1;
         ctrl.stallM = 1'b1;
         ctrl.flushW = 1'b1;
      end else if (PCSrc) begin
         ctrl.flushD = 1'b1;
         ctrl.flushE = 1'b1;
      end else if (mdFull) begin
         ctrl.stallF = 1'b1;
         ctrl.stallD = 1'b1;
         ctrl.stallE = 1'b1;
      end else if (ldUse || noFwd || sbHit) begin
         ctrl.stallF = 1'b1;
         ctrl.stallD = 1'b1;
         ctrl.flushE = 1'b1;
      end
   end

   assign StallF = ctrl.stallF;
   assign StallD = ctrl.stallD;
   assign StallE = ctrl.stallE;
   assign StallM = ctrl.stallM;
   assign FlushD = ctrl.flushD;
   assign FlushE = ctrl.flushE;
   assign FlushW = ctrl.flushW;

   // Only an op that actually leaves E for the mul/div unit is tracked.
   assign mdIssue = MdStartE && !ctrl.stallE && !ctrl.flushE;

   md_scoreboard #(
      .REG_AW   (REG_AW),
      .NUM_REGS (NUM_REGS),
      .MD_DEPTH (MD_DEPTH)
   ) uSb (
      .clk     (clk),
      .rst     (rst),
      .issue   (mdIssue),
      .rd      (RdE),
      .done    (MdDone),
      .done_rd (MdDoneRd),
      .rs1     (Rs1D),
      .rs2     (Rs2D),
      .hit     (sbHit),
      .full    (sbFull)
   );

   // Free-running count of fetch-stall cycles; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst)              StallCount <= '0;
      else if (ctrl.stallF) StallCount <= StallCount + 1'b1;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one instance with forwarding, one without,
// both fed the same stimulus and compared against a behavioural model.
module tb_hazard_scoreboard;

   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;
   localparam int MD_DEPTH = 2;
   localparam int PERF_W   = 32;

   // Expected control bundles, ordered {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_RST  = 7'b0000111;
   localparam logic [6:0] C_MEM  = 7'b1111001;
   localparam logic [6:0] C_BR   = 7'b0000110;
   localparam logic [6:0] C_MD   = 7'b1110000;
   localparam logic [6:0] C_RAW  = 7'b1100010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, MdDoneRd;
   logic              RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrc;
   logic              MdStartE, MdDone, MemReqM, MemReadyM;

   logic [1:0]        fa0, fb0, fa1, fb1;
   logic              sf0, sd0, se0, sm0, fd0, fe0, fw0;
   logic              sf1, sd1, se1, sm1, fd1, fe1, fw1;
   logic [PERF_W-1:0] sc0, sc1;

   hazard_scoreboard #(.REG_AW(REG_AW), .NUM_REGS(NUM_REGS), .FWD_EN(1), .MD_DEPTH(MD_DEPTH), .PERF_W(PERF_W)) dutFwd (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .PCSrc(PCSrc),
      .MdStartE(MdStartE), .MdDone(MdDone), .MdDoneRd(MdDoneRd), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardA(fa0), .ForwardB(fb0), .StallF(sf0), .StallD(sd0), .StallE(se0), .StallM(sm0),
      .FlushD(fd0), .FlushE(fe0), .FlushW(fw0), .StallCount(sc0));

   hazard_scoreboard #(.REG_AW(REG_AW), .NUM_REGS(NUM_REGS), .FWD_EN(0), .MD_DEPTH(MD_DEPTH), .PERF_W(PERF_W)) dutNoFwd (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .PCSrc(PCSrc),
      .MdStartE(MdStartE), .MdDone(MdDone), .MdDoneRd(MdDoneRd), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardA(fa1), .ForwardB(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1),
      .FlushD(fd1), .FlushE(fe1), .FlushW(fw1), .StallCount(sc1));

   int nChecks = 0;
   int nFails  = 0;

   // Behavioural model state, index 0 = forwarding instance, 1 = no-forwarding.
   bit              pend [2][NUM_REGS];
   int              cnt  [2];
   bit [PERF_W-1:0] scM  [2];
   bit [1:0]        eFa [2], eFb [2];
   bit [6:0]        eCtrl [2];

   // Values observed at the last sampling edge.
   logic [1:0]        obsFa [2], obsFb [2];
   logic [6:0]        obsCtrl [2];
   logic [PERF_W-1:0] obsSc [2];

   typedef struct packed {
      logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
      logic       rwE, rwM, rwW, loadE, pcSrc, memReq, memReady;
      logic [1:0] fa, fb;
      logic [6:0] ctrl;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic bit hz(input logic [4:0] rd, input logic [4:0] src);
      return (src != 5'd0) && (rd == src);
   endfunction

   // Expected outputs from the current model state and inputs.
   task automatic modelComb();
      for (int k = 0; k < 2; k++) begin
         bit fwd, rawE, rawM, rawW, ld, nf, sb, full;
         fwd  = (k == 0);
         rawE = RegWriteE && (hz(RdE, Rs1D) || hz(RdE, Rs2D));
         rawM = RegWriteM && (hz(RdM, Rs1D) || hz(RdM, Rs2D));
         rawW = RegWriteW && (hz(RdW, Rs1D) || hz(RdW, Rs2D));
         ld   = fwd && LoadE && rawE;
         nf   = !fwd && (rawE || rawM || rawW);
         sb   = ((Rs1D != 0) && pend[k][Rs1D]) || ((Rs2D != 0) && pend[k][Rs2D]);
         full = MdStartE && (cnt[k] == MD_DEPTH);
         if (rst)                          eCtrl[k] = C_RST;
         else if (MemReqM && !MemReadyM)   eCtrl[k] = C_MEM;
         else if (PCSrc)                   eCtrl[k] = C_BR;
         else if (full)                    eCtrl[k] = C_MD;
         else if (ld || nf || sb)          eCtrl[k] = C_RAW;
         else                              eCtrl[k] = C_NONE;
         eFa[k] = 2'b00;
         eFb[k] = 2'b00;
         if (fwd && !rst) begin
            if (RegWriteM && hz(RdM, Rs1E))      eFa[k] = 2'b10;
            else if (RegWriteW && hz(RdW, Rs1E)) eFa[k] = 2'b01;
            if (RegWriteM && hz(RdM, Rs2E))      eFb[k] = 2'b10;
            else if (RegWriteW && hz(RdW, Rs2E)) eFb[k] = 2'b01;
         end
      end
   endtask

   // Advance the model by one clock edge.
   task automatic modelClock();
      for (int k = 0; k < 2; k++) begin
         bit issue, doneOk;
         if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) pend[k][r] = 1'b0;
            cnt[k] = 0;
            scM[k] = '0;
         end else begin
            issue  = MdStartE && !eCtrl[k][4] && !eCtrl[k][1];
            doneOk = MdDone && (cnt[k] > 0);
            if (doneOk) pend[k][MdDoneRd] = 1'b0;
            if (issue && (RdE != 0)) pend[k][RdE] = 1'b1;
            cnt[k] = cnt[k] + int'(issue) - int'(doneOk);
            if (eCtrl[k][6]) scM[k] = scM[k] + 1'b1;
         end
      end
   endtask

   // One cycle: sample at the falling edge, compare, then clock the model.
   task automatic step();
      string tag;
      modelComb();
      @(negedge clk);
      obsFa[0] = fa0; obsFb[0] = fb0; obsCtrl[0] = {sf0, sd0, se0, sm0, fd0, fe0, fw0}; obsSc[0] = sc0;
      obsFa[1] = fa1; obsFb[1] = fb1; obsCtrl[1] = {sf1, sd1, se1, sm1, fd1, fe1, fw1}; obsSc[1] = sc1;
      for (int k = 0; k < 2; k++) begin
         tag = (k == 0) ? "fwd" : "nofwd";
         check({tag, " ForwardA"}, 32'(obsFa[k]), 32'(eFa[k]));
         check({tag, " ForwardB"}, 32'(obsFb[k]), 32'(eFb[k]));
         check({tag, " ctrl"}, 32'(obsCtrl[k]), 32'(eCtrl[k]));
         check({tag, " StallCount"}, obsSc[k], scM[k]);
      end
      @(posedge clk);
      modelClock();
      #1;
   endtask

   task automatic clearIn();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0; MdDoneRd = '0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrc = 0;
      MdStartE = 0; MdDone = 0; MemReqM = 0; MemReadyM = 0;
   endtask

   initial begin
      bit [PERF_W-1:0] scBefore;

      //              rs1D   rs2D   rs1E   rs2E   rdE    rdM    rdW    wE    wM    wW    ld    pc    mq    mr    fa     fb     ctrl
      vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, C_NONE};
      vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, C_NONE};
      vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd6, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, C_NONE};
      vecs[3]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, C_NONE};
      vecs[4]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_RAW};
      vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
      vecs[6]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
      vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, C_BR};
      vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, C_MEM};
      vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, C_NONE};
      vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, C_MEM};
      vecs[11] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};

      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < NUM_REGS; r++) pend[k][r] = 1'b0;
         cnt[k] = 0;
         scM[k] = '0;
      end

      // Reset: one unchecked edge to load the state, then checked reset cycles.
      clearIn();
      rst = 1'b1;
      @(posedge clk);
      #1;
      step();
      check("reset ctrl", 32'(obsCtrl[0]), 32'(C_RST));
      check("reset StallCount", obsSc[0], 32'd0);
      rst = 1'b0;

      // Table-driven combinational vectors against the forwarding instance.
      for (int i = 0; i < 12; i++) begin
         clearIn();
         Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
         RdE = vecs[i].rdE; RdM = vecs[i].rdM; RdW = vecs[i].rdW;
         RegWriteE = vecs[i].rwE; RegWriteM = vecs[i].rwM; RegWriteW = vecs[i].rwW;
         LoadE = vecs[i].loadE; PCSrc = vecs[i].pcSrc; MemReqM = vecs[i].memReq; MemReadyM = vecs[i].memReady;
         step();
         check($sformatf("vec%0d ForwardA", i), 32'(obsFa[0]), 32'(vecs[i].fa));
         check($sformatf("vec%0d ForwardB", i), 32'(obsFb[0]), 32'(vecs[i].fb));
         check($sformatf("vec%0d ctrl", i), 32'(obsCtrl[0]), 32'(vecs[i].ctrl));
      end

      // Load-use: exactly one stall cycle, counted once.
      clearIn();
      scBefore = scM[0];
      LoadE = 1; RegWriteE = 1; RdE = 5'd7; Rs2D = 5'd7;
      step();
      check("ldUse ctrl", 32'(obsCtrl[0]), 32'(C_RAW));
      clearIn();
      step();
      check("ldUse release", 32'(obsCtrl[0]), 32'(C_NONE));
      check("ldUse StallCount", obsSc[0], scBefore + 1);

      // Scoreboard: x9 pending stalls D until the cycle after MdDone.
      clearIn();
      MdStartE = 1; RdE = 5'd9;
      step();
      clearIn();
      Rs1D = 5'd9;
      repeat (6) begin
         step();
         check("sb stall", 32'(obsCtrl[0]), 32'(C_RAW));
      end
      MdDone = 1; MdDoneRd = 5'd9;
      step();
      check("sb done cycle", 32'(obsCtrl[0]), 32'(C_RAW));
      MdDone = 0;
      step();
      check("sb release", 32'(obsCtrl[0]), 32'(C_NONE));

      // Same-cycle issue and completion on x9: set wins.
      clearIn();
      MdStartE = 1; RdE = 5'd9;
      step();
      MdDone = 1; MdDoneRd = 5'd9;
      step();
      clearIn();
      Rs1D = 5'd9;
      step();
      check("sb set wins", 32'(obsCtrl[0]), 32'(C_RAW));
      MdDone = 1; MdDoneRd = 5'd9;
      step();
      MdDone = 0;
      step();
      check("sb set wins release", 32'(obsCtrl[0]), 32'(C_NONE));

      // Structural: third op waits in E until one completes.
      clearIn();
      MdStartE = 1; RdE = 5'd3;
      step();
      RdE = 5'd4;
      step();
      RdE = 5'd5;
      repeat (3) begin
         step();
         check("md full", 32'(obsCtrl[0]), 32'(C_MD));
      end
      MdDone = 1; MdDoneRd = 5'd3;
      step();
      check("md full done cycle", 32'(obsCtrl[0]), 32'(C_MD));
      MdDone = 0;
      step();
      check("md full release", 32'(obsCtrl[0]), 32'(C_NONE));
      clearIn();
      MdDone = 1; MdDoneRd = 5'd4;
      step();
      MdDoneRd = 5'd5;
      step();
      clearIn();
      Rs1D = 5'd5; Rs2D = 5'd4;
      step();
      check("md drained", 32'(obsCtrl[0]), 32'(C_NONE));

      // Memory wait dominates a taken branch and a load-use hazard.
      clearIn();
      MemReqM = 1; MemReadyM = 0; PCSrc = 1; LoadE = 1; RegWriteE = 1; RdE = 5'd7; Rs1D = 5'd7;
      repeat (3) begin
         step();
         check("mem wait", 32'(obsCtrl[0]), 32'(C_MEM));
      end
      MemReadyM = 1;
      step();
      check("mem ready branch", 32'(obsCtrl[0]), 32'(C_BR));

      // No-forwarding mode stalls on a W producer; forwarding mode bypasses.
      clearIn();
      RegWriteW = 1; RdW = 5'd2; Rs1D = 5'd2; Rs1E = 5'd2;
      step();
      check("nofwd stall", 32'(obsCtrl[1]), 32'(C_RAW));
      check("nofwd ForwardA", 32'(obsFa[1]), 32'd0);
      check("fwd no stall", 32'(obsCtrl[0]), 32'(C_NONE));
      check("fwd ForwardA W", 32'(obsFa[0]), 32'd1);

      // Reset while an op is outstanding and D is stalled on it.
      clearIn();
      MdStartE = 1; RdE = 5'd9;
      step();
      clearIn();
      Rs1D = 5'd9;
      step();
      check("pre-reset stall", 32'(obsCtrl[0]), 32'(C_RAW));
      rst = 1;
      step();
      check("mid reset fwd", 32'(obsCtrl[0]), 32'(C_RST));
      check("mid reset nofwd", 32'(obsCtrl[1]), 32'(C_RST));
      rst = 0;
      step();
      check("post reset no stall", 32'(obsCtrl[0]), 32'(C_NONE));
      check("post reset StallCount fwd", obsSc[0], 32'd0);
      check("post reset StallCount nofwd", obsSc[1], 32'd0);

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 199) == 0);
         Rs1D      = 5'($urandom_range(0, 7));
         Rs2D      = 5'($urandom_range(0, 7));
         Rs1E      = 5'($urandom_range(0, 7));
         Rs2E      = 5'($urandom_range(0, 7));
         RdE       = 5'($urandom_range(0, 7));
         RdM       = 5'($urandom_range(0, 7));
         RdW       = 5'($urandom_range(0, 7));
         RegWriteE = 1'($urandom_range(0, 1));
         RegWriteM = 1'($urandom_range(0, 1));
         RegWriteW = 1'($urandom_range(0, 1));
         LoadE     = ($urandom_range(0, 3) == 0);
         PCSrc     = !LoadE && ($urandom_range(0, 7) == 0);
         MemReqM   = ($urandom_range(0, 2) == 0);
         MemReadyM = ($urandom_range(0, 3) != 0);
         MdStartE  = ($urandom_range(0, 3) == 0);
         MdDone    = !rst && (cnt[0] > 0) && (cnt[1] > 0) && ($urandom_range(0, 2) == 0);
         MdDoneRd  = 5'($urandom_range(0, 7));
         step();
      end
      rst = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
